// File: rtl/opcode_encoder.sv
// One-hot control request -> 8-bit opcode encoder with a small valid/ready FIFO.
// Optional macro OPCODE_ENCODER_PARITY_EN stores an odd-parity bit with each entry.
module opcode_encoder #(
  parameter int DEPTH     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [26:0]              in_line,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_opcode,
  output logic                     out_parity,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     err_pulse,
  output logic [ERR_CNT_W-1:0]     err_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
`ifdef OPCODE_ENCODER_PARITY_EN
  localparam int EW = 9;
`else
  localparam int EW = 8;
`endif

  function automatic logic [7:0] map_line(input int idx);
    logic [7:0] code;
    code = 8'h00;
    if (idx >= 1 && idx <= 4)        code = 8'(8'h10 + idx - 1);
    else if (idx >= 5 && idx <= 14)  code = 8'((idx - 3) << 4);
    else if (idx == 15)              code = 8'hC0;
    else if (idx == 16)              code = 8'hC1;
    else if (idx == 17)              code = 8'hD0;
    else if (idx == 18)              code = 8'hE0;
    else if (idx >= 19 && idx <= 22) code = 8'(8'hF0 + idx - 19);
    return code;
  endfunction

  logic [7:0] line_code [23];

  generate
    for (genvar gi = 0; gi < 23; gi++) begin : g_map
      assign line_code[gi] = map_line(gi);
    end
  endgenerate

  logic [7:0]  enc_code;
  logic [4:0]  hot_cnt;
  logic        well_formed;

  // OR of per-line codes is exact only when a single line is hot, which is
  // the only case that gets enqueued.
  always_comb begin
    enc_code = 8'h00;
    hot_cnt  = 5'd0;
    for (int i = 0; i < 23; i++) begin
      if (in_line[i]) begin
        enc_code = enc_code | line_code[i];
        hot_cnt  = hot_cnt + 5'd1;
      end
    end
    well_formed = (hot_cnt == 5'd1) && (in_line[26:23] == 4'b0000);
  end

  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        level_q, level_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
  logic                 err_pulse_q, err_pulse_d;
  logic [EW-1:0]        mem_q [DEPTH];
  logic [EW-1:0]        entry_d;
  logic [EW-1:0]        head;
  logic                 accept, push, pop, bad;

  assign in_ready  = (level_q != LW'(DEPTH));
  assign out_valid = (level_q != '0);
  assign accept    = in_valid & in_ready;
  assign push      = accept & well_formed;
  assign bad       = accept & ~well_formed;
  assign pop       = out_valid & out_ready;

`ifdef OPCODE_ENCODER_PARITY_EN
  assign entry_d = {~^enc_code, enc_code};
`else
  assign entry_d = enc_code;
`endif

  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d     = level_q;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (!push && pop) level_d = level_q - 1'b1;
    err_pulse_d = bad;
    err_count_d = err_count_q;
    if (bad && (err_count_q != '1)) err_count_d = err_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      err_count_q <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      err_count_q <= err_count_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  // Storage needs no reset: stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= entry_d;
  end

  assign head       = mem_q[rd_ptr_q];
  assign out_opcode = out_valid ? head[7:0] : 8'h00;
`ifdef OPCODE_ENCODER_PARITY_EN
  assign out_parity = out_valid ? head[EW-1] : 1'b0;
`else
  assign out_parity = 1'b0;
`endif
  assign level      = level_q;
  assign err_pulse  = err_pulse_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_opcode_encoder.sv
// Directed self-checking bench for opcode_encoder (either parity build).
module tb_opcode_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [26:0] in_line;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_opcode;
  logic        out_parity;
  logic [2:0]  level;
  logic        err_pulse;
  logic [7:0]  err_count;

  int vectors = 0;
  int miscompares = 0;

  opcode_encoder #(.DEPTH(4), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_line(in_line),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_parity(out_parity),
    .level(level), .err_pulse(err_pulse), .err_count(err_count)
  );

  always #5 clk = ~clk;

  logic [7:0] map_exp [23] = '{8'h00, 8'h10, 8'h11, 8'h12, 8'h13,
                               8'h20, 8'h30, 8'h40, 8'h50, 8'h60,
                               8'h70, 8'h80, 8'h90, 8'hA0, 8'hB0,
                               8'hC0, 8'hC1, 8'hD0, 8'hE0,
                               8'hF0, 8'hF1, 8'hF2, 8'hF3};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic par_exp(input logic [7:0] op);
`ifdef OPCODE_ENCODER_PARITY_EN
    return ~^op;
`else
    return 1'b0;
`endif
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_line = '0;
    step(); step();
    rst = 1'b0;
    check("rst_level", level, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_opcode", out_opcode, 0);
    check("rst_err_count", err_count, 0);
    check("rst_err_pulse", err_pulse, 0);
    check("rst_parity", out_parity, 0);

    // Map sweep: every push is popped by the next cycle's push.
    out_ready = 1'b1;
    for (int i = 0; i < 23; i++) begin
      in_valid = 1'b1;
      in_line  = 27'd1 << i;
      step();
      check($sformatf("map_opcode_%0d", i), out_opcode, map_exp[i]);
      check($sformatf("map_valid_%0d", i), out_valid, 1);
      check($sformatf("map_parity_%0d", i), out_parity, par_exp(map_exp[i]));
      $display("map line %0d -> opcode %02h level %0d", i, out_opcode, level);
    end
    in_valid = 1'b0; in_line = '0;
    step();
    check("map_drain_valid", out_valid, 0);
    check("map_drain_opcode", out_opcode, 0);
    check("map_err_count", err_count, 0);

    // Malformed requests.
    in_valid = 1'b1; in_line = 27'h0;
    step();
    check("bad0_pulse", err_pulse, 1);
    check("bad0_count", err_count, 1);
    check("bad0_valid", out_valid, 0);
    in_line = 27'h3;
    step();
    check("bad1_pulse", err_pulse, 1);
    check("bad1_count", err_count, 2);
    in_line = 27'd1 << 25;
    step();
    check("bad2_pulse", err_pulse, 1);
    check("bad2_count", err_count, 3);
    check("bad2_valid", out_valid, 0);
    in_valid = 1'b0; in_line = '0;
    step();
    check("bad_pulse_clear", err_pulse, 0);
    check("bad_count_hold", err_count, 3);
    check("bad_level", level, 0);
    $display("malformed: err_count %0d", err_count);

    // Fill and backpressure.
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      in_valid = 1'b1;
      in_line  = 27'd1 << k;
      step();
    end
    check("full_level", level, 4);
    check("full_in_ready", in_ready, 0);
    check("full_head", out_opcode, 8'h10);
    out_ready = 1'b1;
    step();
    check("full_pop_level", level, 3);
    check("full_pop_head", out_opcode, 8'h11);
    check("full_pop_in_ready", in_ready, 1);
    out_ready = 1'b0;
    step();
    check("deferred_push_level", level, 4);
    in_valid = 1'b0; in_line = '0;
    $display("backpressure: level %0d head %02h", level, out_opcode);

    // Drain to level 2 (head 0x13, then 0x20).
    out_ready = 1'b1;
    step(); step();
    check("drain_level", level, 2);
    check("drain_head", out_opcode, 8'h13);

    // Simultaneous push/pop at level 2.
    in_valid = 1'b1; in_line = 27'd1 << 19;
    step();
    check("pp1_level", level, 2);
    check("pp1_head", out_opcode, 8'h20);
    step();
    check("pp2_level", level, 2);
    check("pp2_head", out_opcode, 8'hF0);
    step();
    check("pp3_level", level, 2);
    check("pp3_head", out_opcode, 8'hF0);
    in_valid = 1'b0; in_line = '0;
    step();
    check("pp_tail_level", level, 1);
    check("pp_tail_head", out_opcode, 8'hF0);
    step();
    check("pp_empty", out_valid, 0);
    out_ready = 1'b0;
    $display("push/pop: level %0d", level);

    // Build level=3, err_count=5, then reset with a request pending.
    in_valid = 1'b1; in_line = 27'h0;
    step(); step();
    for (int k = 1; k <= 3; k++) begin
      in_line = 27'd1 << k;
      step();
    end
    check("pre_rst_level", level, 3);
    check("pre_rst_err", err_count, 5);
    rst = 1'b1; in_line = 27'd1 << 4;
    step();
    rst = 1'b0; in_valid = 1'b0; in_line = '0;
    check("mid_rst_level", level, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_opcode", out_opcode, 0);
    check("mid_rst_err", err_count, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_pulse", err_pulse, 0);
    step();
    check("mid_rst_no_enq", level, 0);
    $display("mid reset: level %0d err_count %0d", level, err_count);

    // Error counter saturation.
    in_valid = 1'b1; in_line = 27'h0;
    for (int k = 0; k < 260; k++) step();
    in_valid = 1'b0;
    check("err_saturate", err_count, 8'hFF);
    step();
    check("err_saturate_hold", err_count, 8'hFF);
    $display("saturation: err_count %0d", err_count);

    // Parity on lines 0 and 6.
    in_valid = 1'b1; in_line = 27'd1;
    step();
    check("par0_opcode", out_opcode, 8'h00);
    check("par0_valid", out_valid, 1);
    check("par0_parity", out_parity, par_exp(8'h00));
    in_line = 27'd1 << 6;
    step();
    in_valid = 1'b0; in_line = '0;
    check("par_level", level, 2);
    out_ready = 1'b1;
    step();
    check("par6_opcode", out_opcode, 8'h30);
    check("par6_parity", out_parity, par_exp(8'h30));
    step();
    check("par_empty_valid", out_valid, 0);
    check("par_empty_parity", out_parity, 0);
    $display("parity: done level %0d", level);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
